// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick function for the bus arbiters.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    ERR_WAIT = 2'd2
  } arb_state_e;

  // First set bit of req scanning last+1, last+2, ... modulo n.
  // Returns last when nothing is requesting; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                         input logic [2:0] last,
                                         input int n);
    int j;
    rr_pick = last;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int k = MAX_MASTERS; k >= 1; k--) begin
      if (k <= n) begin
        j = int'(last) + k;
        if (j >= n) j = j - n;
        if (req[3'(j)]) rr_pick = 3'(j);
      end
    end
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone N-master / 1-slave bundle; master slices are packed side by side.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w;
  logic [NUM_MASTERS*SW-1:0]         m_sel;
  logic [NUM_MASTERS-1:0]            m_cyc;
  logic [NUM_MASTERS-1:0]            m_stb;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [DATA_WIDTH-1:0]             m_dat_r;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [NUM_MASTERS-1:0]            m_err;

  logic [ADDR_WIDTH-1:0]             s_adr;
  logic [DATA_WIDTH-1:0]             s_dat_w;
  logic [SW-1:0]                     s_sel;
  logic                              s_cyc;
  logic                              s_stb;
  logic                              s_we;
  logic [DATA_WIDTH-1:0]             s_dat_r;
  logic                              s_ack;

  // Arbiter view: consumes master requests and slave replies.
  modport arb (
    input  m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we, s_dat_r, s_ack,
    output m_dat_r, m_ack, m_err, s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we
  );

  // Bus masters drive requests and see replies.
  modport master (
    output m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we,
    input  m_dat_r, m_ack, m_err
  );

  // The shared slave.
  modport slave (
    input  s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we,
    output s_dat_r, s_ack
  );

endinterface

// File: rtl/wb_rr_arb_sel.sv
// Combinational round-robin picker: req + last winner -> valid + next index.
module wb_rr_arb_sel
  import wb_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [MAX_MASTERS-1:0] req_w;
  logic [2:0]             last_w;

  // Widen to the package function's fixed port sizes and pick.
  always_comb begin
    req_w         = '0;
    req_w[N-1:0]  = req;
    last_w        = 3'(last);
    valid         = |req;
    idx           = IW'(rr_pick(req_w, last_w, N));
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone round-robin arbiter. A grant is held for the
// whole CYC burst; a per-transfer watchdog answers a hung slave with ERR.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input logic          clk,
  input logic          rst,
  wb_rr_arbiter_if.arb bus
);

  localparam int IW  = $clog2(NUM_MASTERS);
  localparam int SW  = DATA_WIDTH / 8;
  // Counter reaches TIMEOUT at most, so it needs clog2(TIMEOUT+1) bits.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [WDW-1:0] WD_SAT  = (TIMEOUT > 0) ? WDW'(TIMEOUT) : '1;

  arb_state_e             state, state_d;
  logic [IW-1:0]          grant, grant_d;
  logic [IW-1:0]          last, last_d;
  logic [IW-1:0]          pick;
  logic                   pick_vld;
  logic [WDW-1:0]         wdog, wdog_d;
  logic                   g_cyc, g_stb, in_grant, wd_fire;
  logic [NUM_MASTERS-1:0] ack_v, err_v;

  wb_rr_arb_sel #(.N(NUM_MASTERS)) u_sel (
    .req   (bus.m_cyc),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick)
  );

  assign g_cyc    = bus.m_cyc[grant];
  assign g_stb    = bus.m_stb[grant];
  assign in_grant = (state == GRANT);

  // State, grant and watchdog registers; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      wdog  <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      last  <= last_d;
      wdog  <= wdog_d;
    end
  end

  // Next state plus per-master ACK/ERR steering.
  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last;
    wd_fire = 1'b0;
    ack_v   = '0;
    err_v   = '0;
    unique case (state)
      IDLE: begin
        // Registered decision: slave sees CYC one cycle after the request.
        if (pick_vld) begin
          grant_d = pick;
          last_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Firing requires s_ack low, so ERR and ACK never coincide.
        wd_fire       = (TIMEOUT != 0) && g_cyc && g_stb && !bus.s_ack &&
                        (wdog == WD_LAST);
        ack_v[grant]  = bus.s_ack & g_stb;
        if (!g_cyc) begin
          state_d = IDLE;
        end else if (wd_fire) begin
          err_v[grant] = 1'b1;
          state_d      = ERR_WAIT;
        end
      end
      ERR_WAIT: begin
        // Slave is parked at CYC=0 until the failed master ends its cycle.
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts unanswered STB cycles and saturates instead of wrapping.
  always_comb begin
    wdog_d = wdog;
    if (!in_grant || bus.s_ack || !g_stb) wdog_d = '0;
    else if (wdog != WD_SAT)               wdog_d = wdog + WDW'(1);
  end

  // Slave side follows the granted master only while in GRANT.
  assign bus.s_cyc   = in_grant & g_cyc;
  assign bus.s_stb   = in_grant & g_stb;
  assign bus.s_we    = in_grant & bus.m_we[grant];
  assign bus.s_adr   = in_grant ? bus.m_adr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_dat_w = in_grant ? bus.m_dat_w[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.s_sel   = in_grant ? bus.m_sel[int'(grant)*SW +: SW] : '0;

  // Read data is broadcast; each master qualifies it with its own ACK.
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.m_ack   = ack_v;
  assign bus.m_err   = err_v;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: 4 masters, TIMEOUT=4, small SRAM slave.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic slv_en;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM slave: registered ACK one cycle after STB, one ACK per strobe.
  logic [31:0] mem [0:63];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_ack   <= 1'b0;
      bus.s_dat_r <= '0;
    end else begin
      bus.s_ack <= 1'b0;
      if (slv_en && bus.s_cyc && bus.s_stb && !bus.s_ack) begin
        bus.s_ack <= 1'b1;
        if (bus.s_we)
          for (int b = 0; b < 4; b++)
            if (bus.s_sel[b]) mem[bus.s_adr[7:2]][b*8 +: 8] <= bus.s_dat_w[b*8 +: 8];
        bus.s_dat_r <= mem[bus.s_adr[7:2]];
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [NM-1:0] stray;
  int gseq [16];
  int gn;
  bit gap_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input bit cyc, input bit stb, input bit we,
                     input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc[m]            = cyc;
    bus.m_stb[m]            = stb;
    bus.m_we[m]             = we;
    bus.m_adr[m*AW +: AW]   = adr;
    bus.m_dat_w[m*DW +: DW] = dat;
    bus.m_sel[m*4 +: 4]     = stb ? 4'hF : 4'h0;
  endtask

  // One transfer inside a held CYC; leaves CYC up and STB down.
  task automatic xfer(input int m, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, output logic [31:0] rd, output bit got);
    got = 1'b0;
    rd  = '0;
    drv(m, 1'b1, 1'b1, we, adr, dat);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      stray |= bus.m_ack & ~(NM'(1) << m);
      if (bus.m_ack[m]) begin
        got = 1'b1;
        rd  = bus.m_dat_r;
      end
    end
    drv(m, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Masters in mask each run single-write bursts back to back; record who gets ACKed.
  task automatic run_rr(input logic [NM-1:0] mask, input int nb);
    logic [NM-1:0] down, ack_s;
    logic          cyc_s;
    bit            idle_seen;
    down      = '0;
    gn        = 0;
    gap_ok    = 1'b1;
    idle_seen = 1'b1;
    for (int m = 0; m < NM; m++)
      if (mask[m]) drv(m, 1'b1, 1'b1, 1'b1, 32'h100 + m*4, m);
    for (int c = 0; c < 400 && gn < nb; c++) begin
      step();
      ack_s = bus.m_ack;
      cyc_s = bus.s_cyc;
      if (!cyc_s) idle_seen = 1'b1;
      for (int m = 0; m < NM; m++) begin
        if (down[m]) begin
          drv(m, 1'b1, 1'b1, 1'b1, 32'h100 + m*4, m);
          down[m] = 1'b0;
        end else if (ack_s[m]) begin
          if (!idle_seen) gap_ok = 1'b0;
          idle_seen = 1'b0;
          if (gn < 16) gseq[gn] = m;
          gn++;
          drv(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
          down[m] = 1'b1;
        end
      end
    end
    for (int m = 0; m < NM; m++) drv(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] rd;
    bit          got;
    int          err_at;

    rst         = 1'b1;
    slv_en      = 1'b1;
    stray       = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.m_sel   = '0;
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    step();
    step();

    // Reset state
    chk("rst_s_cyc", 64'(bus.s_cyc), 64'd0);
    chk("rst_m_ack", 64'(bus.m_ack), 64'd0);
    chk("rst_m_err", 64'(bus.m_err), 64'd0);
    chk("rst_s_adr", 64'(bus.s_adr), 64'd0);
    rst = 1'b0;
    step();

    // Single master write then read through the SRAM
    drv(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1 chk("lat_idle", 64'(bus.s_cyc), 64'd0);
    step();
    chk("lat_cyc", 64'(bus.s_cyc), 64'd1);
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, got);
    chk("wr_ack", 64'(got), 64'd1);
    step();
    chk("ack_once", 64'(bus.m_ack[0]), 64'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, got);
    chk("rd_ack", 64'(got), 64'd1);
    chk("rd_data", 64'(rd), 64'hDEADBEEF);
    chk("m1_noack", 64'(stray), 64'd0);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Contention between m0 and m1 right after reset: strict alternation
    do_reset();
    run_rr(4'b0011, 8);
    chk("cont_n", 64'(gn), 64'd8);
    chk("cont_gap", 64'(gap_ok), 64'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("cont_g%0d", i), 64'(gseq[i]), 64'(i % 2));

    // Four-way fairness
    do_reset();
    run_rr(4'b1111, 8);
    chk("fair_n", 64'(gn), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_g%0d", i), 64'(gseq[i]), 64'(i % 4));

    // Burst lock: m1 writes 4 words while m0 waits
    stray = '0;
    xfer(1, 1'b1, 32'h20, 32'hA0A0_0000, rd, got);
    chk("bl_w0", 64'(got), 64'd1);
    drv(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D);
    for (int i = 1; i < 4; i++) begin
      xfer(1, 1'b1, 32'h20 + i*4, 32'hA0A0_0000 + i, rd, got);
      chk($sformatf("bl_w%0d", i), 64'(got), 64'd1);
    end
    chk("bl_lock", 64'(stray), 64'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    xfer(0, 1'b1, 32'h40, 32'h0BAD_F00D, rd, got);
    chk("bl_m0_ack", 64'(got), 64'd1);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, 32'h20 + i*4, 32'h0, rd, got);
      chk($sformatf("bl_rd%0d", i), 64'(rd), 64'(32'hA0A0_0000 + i));
    end
    xfer(0, 1'b0, 32'h40, 32'h0, rd, got);
    chk("bl_rd_m0", 64'(rd), 64'h0BAD_F00D);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Watchdog: slave never answers, ERR on the 4th STB cycle
    slv_en = 1'b0;
    err_at = 0;
    drv(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    for (int c = 1; c <= 8 && err_at == 0; c++) begin
      step();
      if (bus.m_err[0]) begin
        err_at = c;
        chk("wd_no_ack", 64'(bus.m_ack), 64'd0);
      end
    end
    chk("wd_at", 64'(err_at), 64'd4);
    drv(1, 1'b1, 1'b1, 1'b1, 32'h74, 32'h5);
    step();
    chk("wd_pulse", 64'(bus.m_err), 64'd0);
    chk("wd_cyc_drop", 64'(bus.s_cyc), 64'd0);
    step();
    chk("wd_hold", 64'(bus.s_cyc), 64'd0);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wd_idle", 64'(bus.s_cyc), 64'd0);
    step();
    chk("wd_m1_cyc", 64'(bus.s_cyc), 64'd1);
    chk("wd_m1_adr", 64'(bus.s_adr), 64'h74);
    slv_en = 1'b1;
    xfer(1, 1'b1, 32'h74, 32'h5, rd, got);
    chk("wd_m1_ack", 64'(got), 64'd1);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Async reset mid-transfer clears every output at once
    drv(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h1234);
    step();
    step();
    chk("ar_pre_ack", 64'(bus.m_ack[1]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_m_ack", 64'(bus.m_ack), 64'd0);
    chk("ar_m_err", 64'(bus.m_err), 64'd0);
    chk("ar_s_cyc", 64'(bus.s_cyc), 64'd0);
    chk("ar_s_stb", 64'(bus.s_stb), 64'd0);
    chk("ar_s_we", 64'(bus.s_we), 64'd0);
    chk("ar_s_adr", 64'(bus.s_adr), 64'd0);
    chk("ar_s_dat", 64'(bus.s_dat_w), 64'd0);
    chk("ar_s_sel", 64'(bus.s_sel), 64'd0);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("ar_grant_cyc", 64'(bus.s_cyc), 64'd1);
    chk("ar_grant_m0", 64'(bus.s_adr), 64'h60);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone round-robin arbiter. It shares one Wishbone slave, such as the SRAM BFM or an on-chip RAM, between several bus masters.
- A grant is held for the whole CYC burst, so bus transactions are never interleaved.
- A per-transfer watchdog returns ERR to a master whose slave never ACKs, then releases the bus.
- It sits between master BFMs or cores and a shared memory slave in the testbench and SoC fabric.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width (8/16/32/64/128).
- TIMEOUT, 16, cycles STB may wait for ACK before ERR; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- m_adr  in  NUM_MASTERS*ADDR_WIDTH  master addresses; master i uses slice i.
- m_dat_w  in  NUM_MASTERS*DATA_WIDTH  master write data.
- m_sel  in  NUM_MASTERS*(DATA_WIDTH/8)  master byte selects.
- m_cyc  in  NUM_MASTERS  bus request / cycle-valid per master.
- m_stb  in  NUM_MASTERS  strobe per master.
- m_we  in  NUM_MASTERS  write enable per master.
- m_dat_r  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack  out  NUM_MASTERS  ACK per master.
- m_err  out  NUM_MASTERS  watchdog error per master.
- s_adr  out  ADDR_WIDTH  slave address.
- s_dat_w  out  DATA_WIDTH  slave write data.
- s_sel  out  DATA_WIDTH/8  slave byte selects.
- s_cyc, s_stb, s_we  out  1 each  slave control.
- s_dat_r  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave ACK.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, last=NUM_MASTERS-1 (master 0 wins first), wdog=0.
  - All m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w and s_sel are 0.
  - Reset mid-transfer aborts it silently, with no ERR.
- States:
  - IDLE: if any m_cyc is set, pick the first requester scanning last+1, last+2, ... modulo NUM_MASTERS. Register grant and last, then go to GRANT. With no requests, stay in IDLE.
  - GRANT: if m_cyc[grant] is 0, go to IDLE. If the watchdog fires, pulse m_err[grant] for 1 cycle and go to ERR_WAIT.
  - ERR_WAIT: the slave sees CYC=0. When m_cyc[grant] is 0, go to IDLE.
- Arbitration latency:
  - Request to slave CYC takes 1 cycle (registered decision in IDLE).
  - There is at least 1 idle cycle between consecutive grants, which gives the slave a clean CYC deassert.
- Muxing in GRANT (combinational from the granted master):
  - s_cyc=m_cyc[g], s_stb=m_stb[g], s_we=m_we[g], s_adr, s_dat_w and s_sel come from slice g.
  - Outside GRANT, all slave outputs are 0.
- ACK and read data:
  - m_ack[g] = s_ack & (state==GRANT) & m_stb[g]. All other m_ack bits are 0.
  - m_dat_r = s_dat_r unconditionally; masters qualify it with their own ack.
- Simultaneous events:
  - The granted master dropping CYC in the same cycle others request goes to IDLE; arbitration happens next cycle.
  - A stray s_ack outside GRANT is ignored.
- Watchdog:
  - wdog clears when state is not GRANT, s_ack=1, or m_stb[g]=0.
  - It otherwise increments in GRANT.
  - Fires when wdog==TIMEOUT-1 and s_ack=0.
  - ERR and ACK are mutually exclusive.
  - wdog width is clog2(TIMEOUT+1); it must not wrap.
- Fairness: a master that loses in IDLE gets a grant within NUM_MASTERS-1 subsequent grants, provided other bursts terminate.

Decomposition:
- Shared package wb_arb_pkg:
  - Typedef for the state enum (IDLE, GRANT, ERR_WAIT).
  - Function rr_pick(req, last) returning the next index.
- One sub-module: wb_rr_arb_sel. This is the combinational round-robin priority picker (req, last -> valid, idx), reused by future AXI/SVF arbiters.

Test Plan:
- Single master, SRAM slave: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> s_cyc 1 cycle after m_cyc; one m_ack per transfer; read returns 0xDEADBEEF; m_ack[1]=0 throughout.
- Contention: m0 and m1 assert m_cyc in the same cycle after reset -> m0 granted first, then m1 after ≥1 idle cycle. Repeat with both continuously requesting -> grants alternate 0,1,0,1 over 8 bursts.
- Burst lock: m1 holds CYC for 4 back-to-back writes while m0 requests -> m0 sees no ack until m1 drops CYC; m1's 4 words land at 0x20..0x2C intact.
- Watchdog: TIMEOUT=4, slave ack tied 0, m0 strobes -> m_err[0] pulses exactly on the 4th STB cycle, s_cyc drops next cycle, and m1 is granted after m0 drops CYC.
- Async reset: assert rst mid-burst between clock edges -> all outputs 0 immediately. After release, m1 and m0 requesting yields a grant to m0.
- N=4 fairness: all four request continuously -> grant order 0,1,2,3,0 with no master starved.
